// File: rtl/constant_sequencer.sv
// constant_sequencer
// Streams a fixed four-word table of 5-bit constants over a valid/ready
// interface, LOOPS passes per accepted start. Words can be inverted, words
// with a non-zero low pair are flagged, and words equal to a compare value
// are counted (saturating).
module constant_sequencer #(
  parameter int unsigned LOOPS = 2  // passes per start, legal range 1..4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       invert,
  input  logic [4:0] cmp,
  input  logic       ready,
  output logic [4:0] data,
  output logic       valid,
  output logic       low_any,
  output logic       busy,
  output logic       done,
  output logic [3:0] match_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] LAST_IDX  = 2'd3;
  localparam logic [1:0] LAST_PASS = 2'(LOOPS - 1);
  localparam logic [3:0] CNT_MAX   = 4'd15;
  localparam logic [4:0] LOW_MASK  = 5'b00011;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_idx;
  logic [1:0] w_idx_nxt;
  logic [1:0] r_pass;
  logic [1:0] w_pass_nxt;
  logic       r_inv;
  logic       w_inv_nxt;
  logic [4:0] r_cmp;
  logic [4:0] w_cmp_nxt;
  logic [3:0] r_match_cnt;
  logic [3:0] w_match_cnt_nxt;

  logic [4:0] w_word;
  logic [4:0] w_data;
  logic       w_hs;

  // Constant table lookup by current index.
  always_comb begin
    case (r_idx)
      2'd0:    w_word = 5'd13;
      2'd1:    w_word = 5'b1_0010;
      2'd2:    w_word = 5'h1F;
      default: w_word = 5'b0_0000;
    endcase
  end

  // The presented word is derived from held state, so it is stable under
  // backpressure and keeps the last table output while idle.
  assign w_data = w_word ^ {5{r_inv}};
  assign w_hs   = (r_state == S_SEND) && ready;

  // Next-state and datapath update decisions.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_pass_nxt      = r_pass;
    w_inv_nxt       = r_inv;
    w_cmp_nxt       = r_cmp;
    w_match_cnt_nxt = r_match_cnt;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt     = S_SEND;
          w_inv_nxt       = invert;
          w_cmp_nxt       = cmp;
          w_idx_nxt       = 2'd0;
          w_pass_nxt      = 2'd0;
          w_match_cnt_nxt = 4'd0;
        end
      end

      S_SEND: begin
        if (w_hs) begin
          if ((w_data == r_cmp) && (r_match_cnt != CNT_MAX)) begin
            w_match_cnt_nxt = r_match_cnt + 4'd1;
          end
          if ((r_idx == LAST_IDX) && (r_pass == LAST_PASS)) begin
            // Index stays on the last entry so data keeps the final word.
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_idx + 2'd1;
            if (r_idx == LAST_IDX) begin
              w_pass_nxt = r_pass + 2'd1;
            end
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register with asynchronous reset back to the idle configuration.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 2'd0;
      r_pass      <= 2'd0;
      r_inv       <= 1'b0;
      r_cmp       <= 5'd0;
      r_match_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_pass      <= w_pass_nxt;
      r_inv       <= w_inv_nxt;
      r_cmp       <= w_cmp_nxt;
      r_match_cnt <= w_match_cnt_nxt;
    end
  end

  assign data      = w_data;
  assign valid     = (r_state == S_SEND);
  assign busy      = (r_state == S_SEND) || (r_state == S_DONE);
  assign done      = (r_state == S_DONE);
  assign low_any   = |(w_data & LOW_MASK);
  assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_constant_sequencer.sv
// Testbench for constant_sequencer: directed runs on a LOOPS=2 and a LOOPS=4
// instance, with expected words and end-of-run counts queued by the stimulus
// and consumed by per-instance monitors.
module tb_constant_sequencer;

  typedef struct packed {
    logic [4:0] d;
    logic       l;
  } word_t;

  logic       clk = 1'b0;
  logic       rst;

  // LOOPS=2 instance
  logic       start, invert, ready;
  logic [4:0] cmp;
  logic [4:0] data;
  logic       valid, low_any, busy, done;
  logic [3:0] match_cnt;

  // LOOPS=4 instance
  logic       start4, invert4, ready4;
  logic [4:0] cmp4;
  logic [4:0] data4;
  logic       valid4, low_any4, busy4, done4;
  logic [3:0] match_cnt4;

  int n_cmp   = 0;
  int n_err   = 0;
  int n_done  = 0;
  int n_done4 = 0;

  word_t q2[$];
  word_t q4[$];
  int    c2[$];
  int    c4[$];
  word_t m2_w;
  word_t m4_w;

  // Hand-computed table outputs and low-pair flags.
  logic [4:0] plain_d [4];
  logic       plain_l [4];
  logic [4:0] inv_d   [4];
  logic       inv_l   [4];

  constant_sequencer #(.LOOPS(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .invert    (invert),
    .cmp       (cmp),
    .ready     (ready),
    .data      (data),
    .valid     (valid),
    .low_any   (low_any),
    .busy      (busy),
    .done      (done),
    .match_cnt (match_cnt)
  );

  constant_sequencer #(.LOOPS(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .invert    (invert4),
    .cmp       (cmp4),
    .ready     (ready4),
    .data      (data4),
    .valid     (valid4),
    .low_any   (low_any4),
    .busy      (busy4),
    .done      (done4),
    .match_cnt (match_cnt4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input bit to4, input bit inv, input int loops);
    word_t w;
    for (int p = 0; p < loops; p++) begin
      for (int i = 0; i < 4; i++) begin
        w.d = inv ? inv_d[i] : plain_d[i];
        w.l = inv ? inv_l[i] : plain_l[i];
        if (to4) q4.push_back(w);
        else     q2.push_back(w);
      end
    end
  endtask

  task automatic run_start(input bit inv, input logic [4:0] c);
    invert = inv;
    cmp    = c;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic run_start4(input logic [4:0] c);
    cmp4   = c;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic wait_done(input bit is4, input int budget, output int n);
    n = 0;
    while (!(is4 ? done4 : done) && n < budget) begin
      tick();
      n++;
    end
    if (!(is4 ? done4 : done)) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done pulse within %0d cycles (is4=%0d)", budget, is4);
    end
  endtask

  // Monitor for the LOOPS=2 instance: consumes one expected word per handshake
  // and one expected count per done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) begin
        if (q2.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL dut2_extra_word: got %0d expected no word", data);
        end else begin
          m2_w = q2.pop_front();
          check("dut2_data", data, m2_w.d);
          check("dut2_low_any", low_any, m2_w.l);
        end
      end
      if (done) begin
        n_done++;
        if (c2.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL dut2_extra_done: got done with match_cnt %0d expected no done", match_cnt);
        end else begin
          check("dut2_done_match_cnt", match_cnt, c2.pop_front());
        end
      end
    end
  end

  // Monitor for the LOOPS=4 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid4 && ready4) begin
        if (q4.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL dut4_extra_word: got %0d expected no word", data4);
        end else begin
          m4_w = q4.pop_front();
          check("dut4_data", data4, m4_w.d);
          check("dut4_low_any", low_any4, m4_w.l);
        end
      end
      if (done4) begin
        n_done4++;
        if (c4.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL dut4_extra_done: got done with match_cnt %0d expected no done", match_cnt4);
        end else begin
          check("dut4_done_match_cnt", match_cnt4, c4.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n_stall;
    int done_before;

    plain_d[0] = 5'd13; plain_d[1] = 5'd18; plain_d[2] = 5'd31; plain_d[3] = 5'd0;
    plain_l[0] = 1'b1;  plain_l[1] = 1'b1;  plain_l[2] = 1'b1;  plain_l[3] = 1'b0;
    inv_d[0]   = 5'd18; inv_d[1]   = 5'd13; inv_d[2]   = 5'd0;  inv_d[3]   = 5'd31;
    inv_l[0]   = 1'b1;  inv_l[1]   = 1'b1;  inv_l[2]   = 1'b0;  inv_l[3]   = 1'b1;

    rst    = 1'b1;
    start  = 1'b0; invert  = 1'b0; cmp  = 5'd0; ready  = 1'b1;
    start4 = 1'b0; invert4 = 1'b0; cmp4 = 5'd0; ready4 = 1'b1;

    // Reset state
    repeat (2) tick();
    check("rst_data", data, 5'd13);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_match_cnt", match_cnt, 4'd0);
    check("rst_low_any", low_any, 1'b1);
    rst = 1'b0;
    tick();

    // Basic run: cmp=31 matches twice, done on cycle 9, idle on cycle 10
    push_run(1'b0, 1'b0, 2);
    c2.push_back(2);
    run_start(1'b0, 5'd31);
    check("basic_first_valid", valid, 1'b1);
    check("basic_first_data", data, 5'd13);
    check("basic_busy", busy, 1'b1);
    wait_done(1'b0, 30, n);
    check("basic_cycles_to_done", n, 8);
    check("basic_final_cnt", match_cnt, 4'd2);
    tick();
    check("basic_busy_after", busy, 1'b0);
    check("basic_done_after", done, 1'b0);
    check("basic_cnt_held", match_cnt, 4'd2);
    check("basic_data_held", data, 5'd0);

    // Inverted run; invert/cmp changes mid-run must not matter
    push_run(1'b0, 1'b1, 2);
    c2.push_back(2);
    run_start(1'b1, 5'd0);
    repeat (3) tick();
    invert = 1'b0;
    cmp    = 5'd31;
    wait_done(1'b0, 30, n);
    check("inv_cycles_to_done", n + 3, 8);
    tick();

    // Backpressure: three stalled cycles on the word 18
    push_run(1'b0, 1'b0, 2);
    c2.push_back(2);
    run_start(1'b0, 5'd13);
    tick();
    ready = 1'b0;
    n_stall = 1;
    for (int i = 0; i < 3; i++) begin
      check("bp_data_hold", data, 5'd18);
      check("bp_valid_hold", valid, 1'b1);
      check("bp_cnt_hold", match_cnt, 4'd1);
      tick();
      n_stall++;
    end
    ready = 1'b1;
    wait_done(1'b0, 30, n);
    check("bp_cycles_to_done", n + n_stall, 11);
    tick();

    // Start pulsed during SEND is ignored
    push_run(1'b0, 1'b0, 2);
    c2.push_back(2);
    done_before = n_done;
    run_start(1'b0, 5'd0);
    tick();
    invert = 1'b1;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    invert = 1'b0;
    wait_done(1'b0, 30, n);
    check("ign_cycles_to_done", n + 2, 8);
    repeat (3) tick();
    check("ign_done_pulses", n_done - done_before, 1);
    check("ign_idle", busy, 1'b0);

    // Reset during the second word abandons the run without a done pulse
    q2.push_back('{d: 5'd13, l: 1'b1});
    done_before = n_done;
    run_start(1'b0, 5'd13);
    tick();
    check("rstmid_pre_data", data, 5'd18);
    check("rstmid_pre_cnt", match_cnt, 4'd1);
    rst = 1'b1;
    #1;
    check("rstmid_valid", valid, 1'b0);
    check("rstmid_cnt", match_cnt, 4'd0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_data", data, 5'd13);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rstmid_no_done", n_done - done_before, 0);
    push_run(1'b0, 1'b0, 2);
    c2.push_back(2);
    run_start(1'b0, 5'd13);
    check("rstmid_restart_data", data, 5'd13);
    check("rstmid_restart_valid", valid, 1'b1);
    wait_done(1'b0, 30, n);
    check("rstmid_restart_cycles", n, 8);
    tick();

    // LOOPS=4: four back-to-back runs, count restarts at each start
    for (int r = 0; r < 4; r++) begin
      push_run(1'b1, 1'b0, 4);
      c4.push_back(4);
      run_start4(5'd13);
      check("l4_start_cnt", match_cnt4, 4'd0);
      wait_done(1'b1, 40, n);
      check("l4_cycles_to_done", n, 16);
      check("l4_final_cnt", match_cnt4, 4'd4);
      tick();
    end

    // Saturation: preload the counter near its ceiling, then keep matching
    push_run(1'b1, 1'b0, 4);
    c4.push_back(15);
    run_start4(5'd13);
    force u_dut4.r_match_cnt = 4'd14;
    #1;
    release u_dut4.r_match_cnt;
    check("sat_preload", match_cnt4, 4'd14);
    tick();
    check("sat_reach_max", match_cnt4, 4'd15);
    repeat (4) tick();
    check("sat_hold_max", match_cnt4, 4'd15);
    wait_done(1'b1, 40, n);
    tick();
    repeat (2) tick();

    check("q2_drained", q2.size(), 0);
    check("c2_drained", c2.size(), 0);
    check("q4_drained", q4.size(), 0);
    check("c4_drained", c4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
